// File: rtl/ir_presence_filter.sv
// ir_presence_filter
//   Conditions the raw IR receiver pin for the relay stage of the touchless
//   tap: two-flop synchroniser, separate on/off debounce windows, a clean
//   registered presence level, and a maximum-dispense timeout. The timeout
//   holds a lockout until the hand has been clear for a full off window.
//
// Ports
//   clk            system clock (single domain)
//   reset          synchronous, active-high reset
//   ir_pin         raw IR receiver output, asynchronous to clk
//   presence       debounced hand-present level (ACTIVE or CONFIRM_OFF)
//   lockout        high while in timeout lockout
//   timeout_pulse  one-cycle strobe on the first cycle of lockout
module ir_presence_filter #(
  parameter int IR_ACTIVE_LOW = 1,
  parameter int ON_CYCLES     = 1000,
  parameter int OFF_CYCLES    = 5000,
  parameter int MAX_ON_CYCLES = 10000000,
  parameter int CNT_W         = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic ir_pin,
  output logic presence,
  output logic lockout,
  output logic timeout_pulse
);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_CONFIRM_ON  = 3'd1,
    ST_ACTIVE      = 3'd2,
    ST_CONFIRM_OFF = 3'd3,
    ST_LOCKOUT     = 3'd4
  } state_t;

  // Level the pin rests at when nothing is detected; the synchroniser is
  // reset to it so det comes out of reset low.
  localparam logic IDLE_LVL = (IR_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_ON_CYCLES - 1);

  logic             s0_q, s1_q;
  logic             det;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] dbc_q, dbc_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic             pulse_q, pulse_d;

  // ---- synchroniser ----
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_q <= IDLE_LVL;
      s1_q <= IDLE_LVL;
    end else begin
      s0_q <= ir_pin;
      s1_q <= s0_q;
    end
  end

  assign det = (IR_ACTIVE_LOW != 0) ? ~s1_q : s1_q;

  // ---- debounce / dispense-time FSM ----
  always_comb begin
    state_d = state_q;
    dbc_d   = dbc_q;
    run_d   = run_q;
    case (state_q)
      ST_IDLE: begin
        if (det) begin
          state_d = ST_CONFIRM_ON;
          dbc_d   = ONE;
        end
      end
      ST_CONFIRM_ON: begin
        if (!det) begin
          state_d = ST_IDLE;
          dbc_d   = '0;
        end else if (dbc_q == ON_LAST) begin
          state_d = ST_ACTIVE;
          run_d   = '0;
          dbc_d   = '0;
        end else begin
          dbc_d = dbc_q + ONE;
        end
      end
      ST_ACTIVE: begin
        // Timeout wins over any release seen on the same edge.
        if (run_q == MAX_LAST) begin
          state_d = ST_LOCKOUT;
          dbc_d   = '0;
        end else begin
          run_d = run_q + ONE;
          if (!det) begin
            state_d = ST_CONFIRM_OFF;
            dbc_d   = ONE;
          end
        end
      end
      ST_CONFIRM_OFF: begin
        if (run_q == MAX_LAST) begin
          state_d = ST_LOCKOUT;
          dbc_d   = '0;
        end else if (det) begin
          // A short gap does not restart the dispense timer.
          state_d = ST_ACTIVE;
          dbc_d   = '0;
          run_d   = run_q + ONE;
        end else if (dbc_q == OFF_LAST) begin
          state_d = ST_IDLE;
          dbc_d   = '0;
          run_d   = '0;
        end else begin
          dbc_d = dbc_q + ONE;
          run_d = run_q + ONE;
        end
      end
      ST_LOCKOUT: begin
        // Only a full clear window re-arms; a held hand keeps restarting it.
        if (det) begin
          dbc_d = '0;
        end else if (dbc_q == OFF_LAST) begin
          state_d = ST_IDLE;
          dbc_d   = '0;
          run_d   = '0;
        end else begin
          dbc_d = dbc_q + ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        dbc_d   = '0;
        run_d   = '0;
      end
    endcase
  end

  assign pulse_d = (state_d == ST_LOCKOUT) && (state_q != ST_LOCKOUT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dbc_q   <= '0;
      run_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dbc_q   <= dbc_d;
      run_q   <= run_d;
      pulse_q <= pulse_d;
    end
  end

  // ---- outputs: decodes of registered state only ----
  assign presence      = (state_q == ST_ACTIVE) || (state_q == ST_CONFIRM_OFF);
  assign lockout       = (state_q == ST_LOCKOUT);
  assign timeout_pulse = pulse_q;

endmodule

// File: tb/tb_ir_presence_filter.sv
// tb_ir_presence_filter
//   Drives ir_presence_filter (active-low pin, ON=4, OFF=8, MAX_ON=50) with
//   directed hand patterns followed by random ones. A reference model tracks
//   detected/clear streak lengths and dispense time and queues the expected
//   {presence, lockout, timeout_pulse} for every clock edge; a monitor on the
//   falling edge pops and compares.
module tb_ir_presence_filter;

  localparam int ON_C  = 4;
  localparam int OFF_C = 8;
  localparam int MAX_C = 50;

  logic clk = 1'b0;
  logic reset;
  logic ir_pin;
  logic presence, lockout, timeout_pulse;

  int checks = 0;
  int errors = 0;

  ir_presence_filter #(
    .IR_ACTIVE_LOW(1),
    .ON_CYCLES    (ON_C),
    .OFF_CYCLES   (OFF_C),
    .MAX_ON_CYCLES(MAX_C),
    .CNT_W        (24)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ir_pin       (ir_pin),
    .presence     (presence),
    .lockout      (lockout),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: hand seen/clear streaks, time since activation, and the
  // two-sample delay of the pin reaching the decision logic.
  bit m_pres, m_lock, m_pulse;
  int m_on_strk, m_off_strk, m_on_time;
  bit h0, h1;
  logic [2:0] exp_q[$];

  task automatic model_edge(input logic p, input logic r);
    bit det;
    m_pulse = 1'b0;
    if (r) begin
      m_pres = 0; m_lock = 0; m_on_strk = 0; m_off_strk = 0; m_on_time = 0;
      h0 = 0; h1 = 0;
    end else begin
      det = h1;
      h1  = h0;
      h0  = (p == 1'b0);
      if (m_lock) begin
        if (det) m_off_strk = 0;
        else begin
          m_off_strk++;
          if (m_off_strk == OFF_C) begin
            m_lock = 0; m_off_strk = 0; m_on_strk = 0;
          end
        end
      end else if (m_pres) begin
        if (m_on_time == MAX_C - 1) begin
          m_pres = 0; m_lock = 1; m_pulse = 1; m_off_strk = 0;
        end else begin
          m_on_time++;
          if (det) m_off_strk = 0;
          else begin
            m_off_strk++;
            if (m_off_strk == OFF_C) begin
              m_pres = 0; m_off_strk = 0; m_on_strk = 0;
            end
          end
        end
      end else begin
        if (det) begin
          m_on_strk++;
          if (m_on_strk == ON_C) begin
            m_pres = 1; m_on_time = 0; m_on_strk = 0; m_off_strk = 0;
          end
        end else begin
          m_on_strk = 0;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // One clock: inputs held across the edge, model advanced, expectation queued.
  task automatic step(input logic p, input logic r);
    ir_pin = p;
    reset  = r;
    @(posedge clk);
    model_edge(p, r);
    exp_q.push_back({m_pres, m_lock, m_pulse});
    #1;
  endtask

  // Scoreboard monitor.
  logic [2:0] mon_exp, mon_got;
  int         mon_cycle = 0;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_got = {presence, lockout, timeout_pulse};
      mon_cycle++;
      checks++;
      if (mon_got !== mon_exp) begin
        errors++;
        $display("FAIL scoreboard cycle %0d got p/l/t=%b expected %b",
                 mon_cycle, mon_got, mon_exp);
      end
    end
  end

  // Pattern runner: low lo1, high hi1, low lo2, high hi2 (pin levels; low = hand).
  // Records edge indices (0 = first edge of the pattern) of output transitions.
  int pr_rise, pr_fall, pr_high, lk_rise, lk_fall, pl_cnt, pr_falls;

  task automatic run_pattern(input int lo1, input int hi1, input int lo2, input int hi2);
    int  total;
    logic p;
    logic prev_p, prev_l;
    total = lo1 + hi1 + lo2 + hi2;
    pr_rise = -1; pr_fall = -1; pr_high = 0; lk_rise = -1; lk_fall = -1;
    pl_cnt = 0; pr_falls = 0;
    prev_p = presence;
    prev_l = lockout;
    for (int i = 0; i < total; i++) begin
      if (i < lo1)                  p = 1'b0;
      else if (i < lo1 + hi1)       p = 1'b1;
      else if (i < lo1 + hi1 + lo2) p = 1'b0;
      else                          p = 1'b1;
      step(p, 1'b0);
      if (presence && !prev_p && pr_rise < 0) pr_rise = i;
      if (!presence && prev_p) begin
        pr_falls++;
        if (pr_fall < 0) pr_fall = i;
      end
      if (lockout && !prev_l && lk_rise < 0) lk_rise = i;
      if (!lockout && prev_l && lk_fall < 0) lk_fall = i;
      if (presence) pr_high++;
      if (timeout_pulse) pl_cnt++;
      prev_p = presence;
      prev_l = lockout;
    end
  endtask

  initial begin
    int rise6;
    int lvl, len;
    ir_pin = 1'b1;
    reset  = 1'b1;

    // 1: reset held three cycles with no hand, then released.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      chk("rst_presence", presence, 0);
      chk("rst_lockout", lockout, 0);
      chk("rst_pulse", timeout_pulse, 0);
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    chk("post_rst_outputs", {presence, lockout, timeout_pulse}, 0);

    // 2: hand for 20 cycles: rise at k+5, fall at r+9 = k+29.
    run_pattern(20, 15, 0, 0);
    chk("t2_rise", pr_rise, 5);
    chk("t2_fall", pr_fall, 29);
    chk("t2_lock", lk_rise, -1);

    // 3: 3-cycle glitch never asserts; 4-cycle pulse gives k+5 .. k+13.
    run_pattern(3, 30, 0, 0);
    chk("t3_short_rise", pr_rise, -1);
    run_pattern(4, 20, 0, 0);
    chk("t3_pulse_rise", pr_rise, 5);
    chk("t3_pulse_fall", pr_fall, 13);

    // 4: 5-cycle gap mid-dispense keeps presence and the dispense timer.
    run_pattern(20, 5, 45, 20);
    chk("t4_rise", pr_rise, 5);
    chk("t4_falls", pr_falls, 1);
    chk("t4_fall_at_timeout", pr_fall, 55);
    chk("t4_lock_rise", lk_rise, 55);
    chk("t4_lock_fall", lk_fall, 79);

    // 5: hand held 100 cycles: 50 cycles of presence, single strobe, lockout.
    run_pattern(100, 20, 0, 0);
    chk("t5_rise", pr_rise, 5);
    chk("t5_high_cycles", pr_high, MAX_C);
    chk("t5_lock_rise", lk_rise, 55);
    chk("t5_pulse_cnt", pl_cnt, 1);
    chk("t5_lock_fall", lk_fall, 109);
    run_pattern(10, 20, 0, 0);
    chk("t5_rearm_rise", pr_rise, 5);

    // 6: reset ten cycles into dispense, hand still there.
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0);
    chk("t6_active_before_rst", presence, 1);
    step(1'b0, 1'b1);
    chk("t6_rst_presence", presence, 0);
    chk("t6_rst_lockout", lockout, 0);
    rise6 = -1;
    for (int j = 0; j < 10; j++) begin
      step(1'b0, 1'b0);
      if (presence && rise6 < 0) rise6 = j;
    end
    chk("t6_resync_rise", rise6, 5);
    for (int i = 0; i < 80; i++) step(1'b1, 1'b0);

    // Random hand patterns with occasional resets.
    lvl = 1;
    for (int s = 0; s < 120; s++) begin
      lvl = 1 - lvl;
      if ($urandom_range(0, 4) == 0) len = $urandom_range(20, 70);
      else                           len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++)
        step(lvl[0], ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
